fifo_flags: RTL and testbench
=============================

# fifo_flags

Parametrised single-clock FIFO, successor to the team's fixed-size FIFO. Adds programmable almost-full/almost-empty thresholds, an occupancy count, overflow/underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode. It sits between any producer/consumer pair in the same clock domain and is the default buffering block for new datapaths.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥4
- AFULL_TH, DEPTH-2, almost_full asserts when count ≥ AFULL_TH (1..DEPTH)
- AEMPTY_TH, 2, almost_empty asserts when count ≤ AEMPTY_TH (0..DEPTH-1)
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- AW (localparam), clog2(DEPTH), pointer width

- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- we  in  1  write request
- re  in  1  read request
- d_in  in  WIDTH  write data
- d_out  out  WIDTH  read data
- fifoempty  out  1  count == 0
- fifofull  out  1  count == DEPTH
- almost_full  out  1  count ≥ AFULL_TH
- almost_empty  out  1  count ≤ AEMPTY_TH
- count  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: write rejected
- underflow  out  1  one-cycle pulse: read rejected

## Operation
- Read accept: rd_ok = re & !fifoempty.
- Write accept: wr_ok = we & (!fifofull | rd_ok). A write when full is accepted only when a read is accepted in the same cycle.
- Count update: +1 on wr_ok only, −1 on rd_ok only, unchanged on both or neither.
- Pointers wp and rp are AW bits wide and wrap DEPTH-1 → 0 naturally. Fullness comes from count, never from pointer compare.
- Error pulses: overflow = we & !wr_ok; underflow = re & !rd_ok. Both are registered, high for exactly the cycle after the offending request. A rejected request changes no state.
- Empty with we & re together: the write is accepted, the read is rejected, and underflow pulses.
- Standard mode (FWFT=0): on rd_ok, d_out loads mem[rp] at the clock edge. Otherwise d_out holds its last value.
- FWFT mode (FWFT=1): d_out = mem[rp] combinationally whenever !fifoempty; rd_ok pops the entry. When empty, d_out is don't-care; the bench must not check it.
- Reset values: wp=rp=0, count=0, fifoempty=1, fifofull=0, almost_empty=1, almost_full=0 (for AFULL_TH ≥ 1), overflow=underflow=0, d_out=0 in standard mode.
- Reset during traffic: same-cycle we/re are ignored. Memory contents are not cleared and are unobservable afterwards.

## Timing
- Write-to-read latency:
  - Standard mode: data written at edge N is readable with re at N+1; it appears on d_out after the edge at which rd_ok is sampled, so 1 cycle of read latency.
  - FWFT mode: data written at edge N appears on d_out after edge N (combinational from memory and count).
- All flags and count are registered (they derive from count) and reflect accepted operations one edge after the request cycle.
- Sustained we & re with 0 < count < DEPTH gives one write and one read per cycle. Count stays constant and throughput is full.
- No backpressure handshake exists beyond the flags. The producer must gate we with fifofull, or with almost_full for pipelined producers; the consumer must gate re with fifoempty.

## Structure
- Shared package fifo_pkg: clog2 constant function and a common FIFO_MODE_STD / FIFO_MODE_FWFT constant pair. Future FIFO variants reuse both.
- Sub-module fifo_mem: DEPTH×WIDTH dual-port array with synchronous write (we_en, waddr, wdata) and asynchronous read (raddr, rdata).
- Top-level fifo_flags holds the pointers, count, flags, error pulses and the mode-dependent d_out path.
- Elaboration check rejects a non-power-of-two DEPTH and threshold values out of range.

## Test plan
- Reset, then write 16 words 0x01..0x10 (DEPTH=16, FWFT=0) → fifofull=1 and count=16 after the 16th write; almost_full first rises when count=14. Read 16 → d_out returns 0x01..0x10 in order, one cycle after each re; fifoempty=1 at the end.
- Full FIFO, we=1 re=0 for one cycle with d_in=0xAA → overflow pulses for 1 cycle; count stays 16; 0xAA never appears on d_out.
- Empty FIFO, re=1 → underflow pulse, count stays 0, d_out unchanged. Then we=re=1 with d_in=0x5C → count=1, underflow pulses, a subsequent read yields 0x5C.
- Full FIFO, we=re=1 for 20 cycles with incrementing data → count stays 16, no overflow, and output order is preserved across pointer wrap.
- FWFT=1: write 0x3E into empty FIFO → d_out=0x3E the cycle after the write, with no re. Read it → fifoempty=1 the next cycle.
- Reset asserted mid-traffic with count=7 → the next cycle shows count=0, fifoempty=1, almost_empty=1, no error pulses, d_out=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family.
// Provides a constant clog2 helper for sizing pointers and the read-mode
// constants used to select standard or first-word-fall-through behaviour.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Smallest n with 2**n >= value; usable in parameter expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage array for the FIFO family.
// Ports:
//   clk    - write clock
//   we_en  - write enable, stores wdata at waddr on the rising edge
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - asynchronous read data, mem[raddr]
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we_en,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Contents are never reset; the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (we_en) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/fifo_flags.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, overflow/underflow error pulses and
// a selectable first-word-fall-through read mode.
// Ports:
//   clk          - clock, all state updates on the rising edge
//   rst          - synchronous active-high reset
//   we / d_in    - write request and write data
//   re           - read request
//   d_out        - read data (registered in standard mode, combinational
//                  head-of-queue in FWFT mode)
//   fifoempty    - count == 0
//   fifofull     - count == DEPTH
//   almost_full  - count >= AFULL_TH
//   almost_empty - count <= AEMPTY_TH
//   count        - occupancy 0..DEPTH
//   overflow     - one-cycle pulse after a rejected write
//   underflow    - one-cycle pulse after a rejected read
module fifo_flags
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = FIFO_MODE_STD,
    localparam int AW       = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             re,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic             fifoempty,
    output logic             fifofull,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_C  = (AW+1)'(AFULL_TH);
    localparam logic [AW:0] AEMPTY_C = (AW+1)'(AEMPTY_TH);

    // Refuse to build with a geometry or thresholds the flag logic cannot honour.
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gen_badDepth
        $error("fifo_flags: DEPTH must be a power of two and at least 4");
    end
    if ((AFULL_TH < 1) || (AFULL_TH > DEPTH)) begin : gen_badAfull
        $error("fifo_flags: AFULL_TH must be within 1..DEPTH");
    end
    if ((AEMPTY_TH < 0) || (AEMPTY_TH > DEPTH - 1)) begin : gen_badAempty
        $error("fifo_flags: AEMPTY_TH must be within 0..DEPTH-1");
    end
    if (WIDTH < 1) begin : gen_badWidth
        $error("fifo_flags: WIDTH must be at least 1");
    end

    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_count;
    logic             r_empty;
    logic             r_full;
    logic             r_almostFull;
    logic             r_almostEmpty;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_rdOk;
    logic             w_wrOk;
    logic [AW:0]      w_countNext;
    logic [WIDTH-1:0] w_rdata;

    // A write into a full FIFO is legal only when a read frees a slot in
    // the same cycle; a read from an empty FIFO is never legal, so an
    // empty FIFO with both requests takes the write and rejects the read.
    assign w_rdOk = re & ~r_empty;
    assign w_wrOk = we & (~r_full | w_rdOk);

    always_comb begin
        w_countNext = r_count;
        case ({w_wrOk, w_rdOk})
            2'b10:   w_countNext = r_count + (AW+1)'(1);
            2'b01:   w_countNext = r_count - (AW+1)'(1);
            default: w_countNext = r_count;
        endcase
    end

    // Flags are registered from the next count so they line up with count
    // itself, one edge after the request cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp          <= '0;
            r_rp          <= '0;
            r_count       <= '0;
            r_empty       <= 1'b1;
            r_full        <= 1'b0;
            r_almostFull  <= ((AW+1)'(0) >= AFULL_C);
            r_almostEmpty <= 1'b1;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            if (w_wrOk) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_rdOk) begin
                r_rp <= r_rp + AW'(1);
            end
            r_count       <= w_countNext;
            r_empty       <= (w_countNext == '0);
            r_full        <= (w_countNext == DEPTH_C);
            r_almostFull  <= (w_countNext >= AFULL_C);
            r_almostEmpty <= (w_countNext <= AEMPTY_C);
            r_overflow    <= we & ~w_wrOk;
            r_underflow   <= re & ~w_rdOk;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we_en (w_wrOk & ~rst),
        .waddr (r_wp),
        .wdata (d_in),
        .raddr (r_rp),
        .rdata (w_rdata)
    );

    // FWFT presents the head entry directly; standard mode captures it on
    // each accepted read and otherwise holds the last value.
    if (FWFT == FIFO_MODE_FWFT) begin : gen_fwft
        assign d_out = w_rdata;
    end else begin : gen_std
        logic [WIDTH-1:0] r_dout;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_dout <= '0;
            end else if (w_rdOk) begin
                r_dout <= w_rdata;
            end
        end

        assign d_out = r_dout;
    end

    assign fifoempty    = r_empty;
    assign fifofull     = r_full;
    assign almost_full  = r_almostFull;
    assign almost_empty = r_almostEmpty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_flags.sv
// Testbench for fifo_flags: a standard-mode and an FWFT-mode instance share
// the same stimulus. A table of vectors with hand-computed expectations
// covers the scripted fill/overflow/drain/underflow sequence; random and
// hand-written sequences are checked against a queue-based model.
module tb_fifo_flags;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 16;
    localparam int AFULL  = DEPTH - 2;
    localparam int AEMPTY = 2;

    typedef struct {
        logic       we;
        logic       re;
        logic [7:0] din;
        logic [4:0] cnt;
        logic       emp;
        logic       ful;
        logic       af;
        logic       ae;
        logic       ovf;
        logic       unf;
        logic [7:0] dout;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       we;
    logic       re;
    logic [7:0] din;

    logic [7:0] sDout;
    logic       sEmpty, sFull, sAf, sAe, sOvf, sUnf;
    logic [4:0] sCount;
    logic [7:0] fDout;
    logic       fEmpty, fFull, fAf, fAe, fOvf, fUnf;
    logic [4:0] fCount;

    int errors = 0;
    int checks = 0;

    logic [7:0] mQ[$];
    logic [7:0] mDout;
    logic       mOvf;
    logic       mUnf;

    vec_t vecs[$];

    fifo_flags #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_TH(AFULL), .AEMPTY_TH(AEMPTY), .FWFT(0)
    ) dutStd (
        .clk(clk), .rst(rst), .we(we), .re(re), .d_in(din), .d_out(sDout),
        .fifoempty(sEmpty), .fifofull(sFull), .almost_full(sAf),
        .almost_empty(sAe), .count(sCount), .overflow(sOvf), .underflow(sUnf)
    );

    fifo_flags #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_TH(AFULL), .AEMPTY_TH(AEMPTY), .FWFT(1)
    ) dutFwft (
        .clk(clk), .rst(rst), .we(we), .re(re), .d_in(din), .d_out(fDout),
        .fifoempty(fEmpty), .fifofull(fFull), .almost_full(fAf),
        .almost_empty(fAe), .count(fCount), .overflow(fOvf), .underflow(fUnf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic w, input logic r, input logic [7:0] d,
                                   input int c, input logic o, input logic u,
                                   input logic [7:0] q);
        vec_t v;
        v.we   = w;
        v.re   = r;
        v.din  = d;
        v.cnt  = 5'(c);
        v.emp  = (c == 0);
        v.ful  = (c == DEPTH);
        v.af   = (c >= AFULL);
        v.ae   = (c <= AEMPTY);
        v.ovf  = o;
        v.unf  = u;
        v.dout = q;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge, let the rising edge
    // take it, then advance the reference model to the post-edge state.
    task automatic applyStimulus(input logic r, input logic w, input logic rd, input logic [7:0] d);
        logic rdOk;
        logic wrOk;
        @(negedge clk);
        rst = r;
        we  = w;
        re  = rd;
        din = d;
        @(posedge clk);
        #1;
        if (r) begin
            mQ.delete();
            mDout = 8'h00;
            mOvf  = 1'b0;
            mUnf  = 1'b0;
        end else begin
            rdOk = rd && (mQ.size() > 0);
            wrOk = w && ((mQ.size() < DEPTH) || rdOk);
            mOvf = w && !wrOk;
            mUnf = rd && !rdOk;
            if (rdOk) mDout = mQ.pop_front();
            if (wrOk) mQ.push_back(d);
        end
    endtask

    task automatic checkModel(input string tag);
        int n;
        n = mQ.size();
        checkOutput({tag, ".std.count"}, int'(sCount), n);
        checkOutput({tag, ".std.empty"}, int'(sEmpty), int'(n == 0));
        checkOutput({tag, ".std.full"},  int'(sFull),  int'(n == DEPTH));
        checkOutput({tag, ".std.afull"}, int'(sAf),    int'(n >= AFULL));
        checkOutput({tag, ".std.aempty"}, int'(sAe),   int'(n <= AEMPTY));
        checkOutput({tag, ".std.ovf"},   int'(sOvf),   int'(mOvf));
        checkOutput({tag, ".std.unf"},   int'(sUnf),   int'(mUnf));
        checkOutput({tag, ".std.dout"},  int'(sDout),  int'(mDout));
        checkOutput({tag, ".fwft.count"}, int'(fCount), n);
        checkOutput({tag, ".fwft.empty"}, int'(fEmpty), int'(n == 0));
        checkOutput({tag, ".fwft.full"},  int'(fFull),  int'(n == DEPTH));
        checkOutput({tag, ".fwft.afull"}, int'(fAf),    int'(n >= AFULL));
        checkOutput({tag, ".fwft.aempty"}, int'(fAe),   int'(n <= AEMPTY));
        checkOutput({tag, ".fwft.ovf"},  int'(fOvf),   int'(mOvf));
        checkOutput({tag, ".fwft.unf"},  int'(fUnf),   int'(mUnf));
        if (n > 0) begin
            checkOutput({tag, ".fwft.dout"}, int'(fDout), int'(mQ[0]));
        end
    endtask

    task automatic checkVector(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        checkOutput({tag, ".count"}, int'(sCount), int'(v.cnt));
        checkOutput({tag, ".empty"}, int'(sEmpty), int'(v.emp));
        checkOutput({tag, ".full"},  int'(sFull),  int'(v.ful));
        checkOutput({tag, ".afull"}, int'(sAf),    int'(v.af));
        checkOutput({tag, ".aempty"}, int'(sAe),   int'(v.ae));
        checkOutput({tag, ".ovf"},   int'(sOvf),   int'(v.ovf));
        checkOutput({tag, ".unf"},   int'(sUnf),   int'(v.unf));
        checkOutput({tag, ".dout"},  int'(sDout),  int'(v.dout));
        checkOutput({tag, ".fwft.count"}, int'(fCount), int'(v.cnt));
        checkOutput({tag, ".fwft.ovf"},   int'(fOvf),   int'(v.ovf));
        checkOutput({tag, ".fwft.unf"},   int'(fUnf),   int'(v.unf));
        if (!v.emp) begin
            checkOutput({tag, ".fwft.dout"}, int'(fDout), int'(mQ[0]));
        end
    endtask

    initial begin
        rst = 1'b1;
        we  = 1'b0;
        re  = 1'b0;
        din = 8'h00;
        mDout = 8'h00;
        mOvf  = 1'b0;
        mUnf  = 1'b0;

        // Scripted fill, overflow attempt, drain, underflow, empty we&re.
        for (int i = 1; i <= DEPTH; i++) vecs.push_back(mkVec(1, 0, 8'(i), i, 0, 0, 8'h00));
        vecs.push_back(mkVec(1, 0, 8'hAA, DEPTH, 1, 0, 8'h00));
        for (int k = 1; k <= DEPTH; k++) vecs.push_back(mkVec(0, 1, 8'h00, DEPTH - k, 0, 0, 8'(k)));
        vecs.push_back(mkVec(0, 1, 8'h00, 0, 0, 1, 8'h10));
        vecs.push_back(mkVec(1, 1, 8'h5C, 1, 0, 1, 8'h10));
        vecs.push_back(mkVec(0, 1, 8'h00, 0, 0, 0, 8'h5C));

        applyStimulus(1, 0, 0, 8'h00);
        applyStimulus(1, 0, 0, 8'h00);
        checkModel("reset");
        checkOutput("reset.std.dout.const", int'(sDout), 0);
        checkOutput("reset.aempty.const", int'(sAe), 1);

        foreach (vecs[i]) begin
            applyStimulus(0, vecs[i].we, vecs[i].re, vecs[i].din);
            checkVector(i, vecs[i]);
        end

        // Full FIFO with simultaneous read and write across pointer wrap.
        while (mQ.size() < DEPTH) begin
            applyStimulus(0, 1, 0, 8'($urandom));
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 1, 1, 8'(8'h80 + i));
            checkModel($sformatf("wrap%0d", i));
            checkOutput($sformatf("wrap%0d.count16", i), int'(sCount), DEPTH);
            checkOutput($sformatf("wrap%0d.noovf", i), int'(sOvf), 0);
        end

        // Reset in the middle of traffic at count 7.
        applyStimulus(1, 0, 0, 8'h00);
        for (int i = 0; i < 7; i++) applyStimulus(0, 1, 0, 8'(8'h30 + i));
        checkOutput("pre_reset.count", int'(sCount), 7);
        applyStimulus(1, 1, 1, 8'hEE);
        checkModel("midreset");
        checkOutput("midreset.count", int'(sCount), 0);
        checkOutput("midreset.empty", int'(sEmpty), 1);
        checkOutput("midreset.aempty", int'(sAe), 1);
        checkOutput("midreset.ovf", int'(sOvf), 0);
        checkOutput("midreset.unf", int'(sUnf), 0);
        checkOutput("midreset.dout", int'(sDout), 0);

        // FWFT: written word is visible without a read request.
        applyStimulus(0, 1, 0, 8'h3E);
        checkOutput("fwft.first", int'(fDout), 8'h3E);
        checkOutput("fwft.std_hold", int'(sDout), 0);
        applyStimulus(0, 0, 0, 8'h00);
        checkOutput("fwft.hold", int'(fDout), 8'h3E);
        applyStimulus(0, 0, 1, 8'h00);
        checkOutput("fwft.empty_after", int'(fEmpty), 1);
        checkOutput("fwft.std_read", int'(sDout), 8'h3E);

        // Random traffic, alternating write-heavy and read-heavy phases.
        for (int i = 0; i < 400; i++) begin
            int wBias;
            wBias = (((i / 80) % 2) == 0) ? 75 : 25;
            applyStimulus(($urandom_range(0, 199) == 0),
                          ($urandom_range(0, 99) < wBias),
                          ($urandom_range(0, 99) < (100 - wBias)),
                          8'($urandom));
            checkModel($sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
